// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, captures combinational imem data into a
// 2-entry buffer handed to decode over valid/ready, with redirect, halt and fault handling.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0004,
    parameter logic [31:0] MEM_SIZE  = 32'h0000_0800,
    parameter logic [31:0] HALT_INSN = 32'h0000_000D
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] deliver_count
);

    // state    | meaning
    // ST_RUN   | fetching while the buffer has room
    // ST_HALT  | halt word enqueued, buffer drains, no fetch
    // ST_FAULT | illegal pc seen, buffer drains, no fetch
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] deliver_count_q, deliver_count_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] pc_buf_q [2];
    logic [31:0] pc_buf_d [2];
    logic [31:0] instr_buf_q [2];
    logic [31:0] instr_buf_d [2];
    logic        out_fire;
    logic [1:0]  count_pop;

    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'd4) && (a <= MEM_SIZE);
    endfunction

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        fault_addr_d    = fault_addr_q;
        deliver_count_d = deliver_count_q;
        pc_buf_d        = pc_buf_q;
        instr_buf_d     = instr_buf_q;
        out_fire        = (count_q != 2'd0) && out_ready;
        count_pop       = count_q - {1'b0, out_fire};
        count_d         = count_pop;

        if (out_fire) begin
            deliver_count_d = deliver_count_q + 32'd1;
            pc_buf_d[0]     = pc_buf_q[1];
            instr_buf_d[0]  = instr_buf_q[1];
        end

        if (redirect_valid) begin
            count_d = 2'd0;
            pc_d    = redirect_pc;
            if (is_legal(redirect_pc)) begin
                state_d = ST_RUN;
            end else begin
                state_d      = ST_FAULT;
                fault_addr_d = redirect_pc;
            end
        end else if (state_q == ST_RUN && (count_q < 2'd2 || out_fire)) begin
            if (is_legal(pc_q)) begin
                // count_pop is at most 1 here, so bit 0 selects the free slot
                pc_buf_d[count_pop[0]]    = pc_q;
                instr_buf_d[count_pop[0]] = imem_data;
                count_d                   = count_pop + 2'd1;
                pc_d                      = pc_q + 32'd4;
                if (imem_data == HALT_INSN) begin
                    state_d = ST_HALT;
                end
            end else begin
                state_d      = ST_FAULT;
                fault_addr_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            pc_q            <= RESET_PC;
            fault_addr_q    <= 32'd0;
            deliver_count_q <= 32'd0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            fault_addr_q    <= fault_addr_d;
            deliver_count_q <= deliver_count_d;
            count_q         <= count_d;
        end
        pc_buf_q    <= pc_buf_d;
        instr_buf_q <= instr_buf_d;
    end

    assign imem_addr     = pc_q;
    assign out_valid     = (count_q != 2'd0);
    assign out_pc        = pc_buf_q[0];
    assign out_instr     = instr_buf_q[0];
    assign halted        = (state_q == ST_HALT);
    assign fault         = (state_q == ST_FAULT);
    assign fault_addr    = fault_addr_q;
    assign deliver_count = deliver_count_q;

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the instruction memory. It owns the program counter, drives the memory address, and captures the combinational read data in the same cycle. Fetched {pc, instruction} pairs go into a 2-entry buffer and are handed to decode over a valid/ready handshake. The block also handles branch/jump redirects, halt-on-break and address faults.

Parameters:
RESET_PC, 32'h0000_0004, PC loaded on reset (first instruction word).
MEM_SIZE, 32'h0000_0800, instruction memory size in bytes; legal PC range is 4..MEM_SIZE inclusive.
HALT_INSN, 32'h0000_000D, encoding that stops fetch once it has been enqueued.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
imem_addr  output  32  fetch address, equal to the PC register
imem_data  input  32  instruction word read combinationally at imem_addr
out_valid  output  1  buffer head holds a valid entry
out_ready  input  1  decode accepts the head entry
out_instr  output  32  head instruction
out_pc  output  32  head PC
redirect_valid  input  1  flush the buffer and restart fetch at redirect_pc
redirect_pc  input  32  target address
halted  output  1  state is HALT
fault  output  1  state is FAULT
fault_addr  output  32  offending address, latched on entering FAULT
deliver_count  output  32  number of completed out_valid&&out_ready transfers

Behaviour:
- Reset (rst=1 at an edge) overrides everything: pc=RESET_PC, buffer count=0, state=RUN, fault_addr=0, deliver_count=0. As a result out_valid=0, halted=0, fault=0 and imem_addr=RESET_PC. Reset applies the same way mid-operation and discards buffer contents.
- States: RUN, HALT, FAULT.
- out_fire = out_valid && out_ready. deliver_count increments by 1 on every out_fire, including in the cycle of a redirect. It wraps modulo 2^32.
- Legal pc: pc[1:0]==0 and 4 <= pc <= MEM_SIZE.
- Fetch condition: state RUN, no redirect_valid, pc legal, and (count<2 or out_fire). When met, {pc, imem_data} is enqueued at the edge and pc <= pc+4. Zero-latency capture: the entry is visible at the head the cycle after the address was presented, if the buffer was empty.
- If state is RUN, there is no redirect, pc is illegal and the buffer has space: state <= FAULT and fault_addr <= pc. Nothing is enqueued. Entries already buffered still drain.
- If an enqueued word equals HALT_INSN, state <= HALT. The halt instruction itself is delivered and pc advances past it. In HALT nothing is fetched; the buffer drains.
- Buffer: 2-entry FIFO, head on outputs. Enqueue and dequeue in the same cycle are allowed when full, so throughput is 1/cycle. Entries are never dropped and out_valid never deasserts without a fire unless a flush occurs. Head fields hold stable while out_valid && !out_ready.
- redirect_valid takes priority over fetch in all states:
  - count <= 0 and no enqueue that cycle; a simultaneous out_fire still counts as delivered.
  - If redirect_pc is legal: pc <= redirect_pc, state <= RUN. This clears both HALT and FAULT, and fault_addr holds its last value.
  - If redirect_pc is illegal: state <= FAULT, fault_addr <= redirect_pc, pc <= redirect_pc.
- Fetch resumes the cycle after a legal redirect.
- pc+4 past MEM_SIZE is caught by the illegal-pc rule on the next fetch attempt. 32-bit pc wrap is therefore unreachable while in RUN.
- out_pc and out_instr are don't-care when out_valid=0. The bench checks them only when valid.

Test Plan:
- Streaming: reset, imem model returns addr^32'hA5A5_0000, out_ready=1 -> out_pc 4, 8, 12, ... on consecutive cycles; first out_valid one cycle after reset release; deliver_count matches.
- Backpressure: out_ready=0 for 5 cycles after the first valid -> buffer fills to 2, imem_addr holds at 12, head stays pc=4. Release -> pcs 4, 8, 12 with no gaps or duplicates.
- Redirect: while full and out_ready=1, assert redirect_valid with redirect_pc=0x100 -> head accepted (deliver_count+1), buffer flushed, next delivered pc=0x100. Also redirect_pc=0x102 -> fault=1, fault_addr=0x102, no further out_valid.
- Halt: word at pc 0x10 = 32'h0000_000D -> instruction at 0x10 delivered, halted=1, imem_addr frozen at 0x14, no more deliveries. Redirect to 0x40 -> halted=0, fetch from 0x40.
- End of memory: redirect to MEM_SIZE-4 (0x7FC) -> 0x7FC and 0x800 delivered, then fault=1 with fault_addr=0x804.
- Reset mid-operation: rst during a full, stalled buffer and during FAULT -> next cycle out_valid=0, fault=0, imem_addr=4, deliver_count=0.
